pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised multi-bit adder: a + b + carry_in -> sum, carry_out, split into STAGES pipeline
//  stages of CHUNK = WIDTH/STAGES bits each. The carry ripples one chunk per cycle between stages.
//  Valid/ready handshake on both sides. Full backpressure with a global stall.
//  Datapath adder for accumulators and address generators. Replaces single-bit combinational full adders.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; must be a multiple of STAGES (elaboration-time $error otherwise)
//  STAGES   4  pipeline depth = latency in cycles; 1 <= STAGES <= WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a + b + carry_in, modulo 2^WIDTH
//  carry_out  out  1      carry out of bit WIDTH-1
//  overflow   out  1      signed overflow (present only with PIPE_ADD_OVF_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0; sum = 0;
//    carry_out = 0; overflow = 0. In-flight operations are discarded, not completed.
//  - stall = out_valid & ~out_ready. in_ready = ~stall (combinational; 1 while in reset).
//  - Accept: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - When stall=0, every stage register advances every cycle, and bubbles advance as valid=0.
//    When stall=1, every stage register, valid bit and output register holds.
//  - Stage k (0..STAGES-1) adds chunk k of A and B plus the carry registered from stage k-1
//    (stage 0 uses carry_in). It stores sum chunk k and carries the upper, not-yet-added chunks of A and B forward.
//    Lower sum chunks are already computed and pass through unchanged (skew triangle).
//  - Latency: operand accepted at cycle N -> out_valid=1 at the start of cycle N+STAGES, if there is no stall.
//    Throughput is 1 result/cycle. Results leave in acceptance order.
//  - Outputs are registered. sum, carry_out and overflow are stable while out_valid & ~out_ready.
//  - Holding in_valid with no acceptance is legal. The source must keep a/b/carry_in stable until accepted.
//  - Wrap: 0xFFFF_FFFF + 0x0000_0001 + 0 -> sum=0, carry_out=1 (WIDTH=32).
//  - STAGES=1 degenerates to one registered WIDTH-bit add with latency 1.
//  - Simultaneous accept and output transfer in the same cycle are both honoured, with no bubble inserted.
// CONFIGURATION
//  PIPE_ADD_OVF_EN defined: port overflow exists. At the final stage it is computed as
//    a[W-1]==b[W-1] && sum[W-1]!=a[W-1], with the operand MSBs carried along the pipe.
//    It is registered alongside sum and resets to 0.
//  PIPE_ADD_OVF_EN undefined: overflow port and its MSB pipeline registers are absent. All other behaviour is identical.
// STRUCTURE
//  - Package pipelined_adder_pkg: function chunk_w(WIDTH,STAGES).
//    Typedef-free localparam helpers CHUNK_MAX=64, used for the $error guard.
//  - Sub-module adder_chunk #(W): combinational W-bit ripple adder (a, b, cin -> s, cout).
//    Built as a generate chain of single-bit full adders. One instance per stage.
//  - Top: generate loop over stages; per-stage valid bit, carry reg, partial sum reg, remaining-operand regs.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, in_ready=1. Deassert rst_n -> first result exactly STAGES cycles after first accept.
//  2 Directed: 0xFFFFFFFF+0x00000001+0 -> sum=0x00000000, carry_out=1. 0x12345678+0x0000FFFF+1 -> sum=0x12355678, carry_out=0.
//  3 Streaming: 1000 random back-to-back accepts, out_ready=1 -> one result/cycle, in order, matching a scoreboard.
//  4 Backpressure: out_ready=0 for 5 cycles with a full pipe -> in_ready=0, outputs held stable, no loss or duplication after release.
//  5 Mid-flight reset: assert rst_n=0 with 3 ops in flight -> out_valid falls immediately. None of the 3 results ever appear.
//  6 PIPE_ADD_OVF_EN: 0x7FFFFFFF+1 -> overflow=1; 0x80000000+0x80000000 -> overflow=1, carry_out=1, sum=0. Rerun tests 1-5 with the macro undefined.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared sizing helpers for the pipelined adder.
package pipelined_adder_pkg;

    localparam int CHUNK_MAX = 64;

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? width / stages : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder built from a chain of full adders.
// Zero latency; no flow control.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder: one CHUNK-bit slice per stage, carry registered between stages (PIPE_ADD_OVF_EN adds overflow).
// Latency STAGES cycles, one result per cycle; a stalled output freezes every stage and drops in_ready.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || CHUNK > CHUNK_MAX) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH=%0d must be a multiple of STAGES=%0d (1..WIDTH)", WIDTH, STAGES);
    end

    logic stall;

    // Stage k holds the finished low sum bits and only the operand bits still to be added.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int HI = (k + 1) * CHUNK;

        logic [CHUNK-1:0] a_c, b_c, s_c;
        logic             c_in, c_out, vld_d;
        logic [HI-1:0]    sum_d, sum_q;
        logic             vld_q, cry_q;

        if (k == 0) begin : g_src
            assign a_c   = a[CHUNK-1:0];
            assign b_c   = b[CHUNK-1:0];
            assign c_in  = carry_in;
            assign vld_d = in_valid & in_ready;
            assign sum_d = s_c;
        end else begin : g_src
            assign a_c   = stg[k-1].g_rem.a_q[CHUNK-1:0];
            assign b_c   = stg[k-1].g_rem.b_q[CHUNK-1:0];
            assign c_in  = stg[k-1].cry_q;
            assign vld_d = stg[k-1].vld_q;
            assign sum_d = {s_c, stg[k-1].sum_q};
        end

        adder_chunk #(.W(CHUNK)) u_add (
            .a    (a_c),
            .b    (b_c),
            .cin  (c_in),
            .s    (s_c),
            .cout (c_out)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (!stall) begin
                vld_q <= vld_d;
                cry_q <= c_out;
                sum_q <= sum_d;
            end
        end

        if (HI < WIDTH) begin : g_rem
            localparam int RW = WIDTH - HI;
            logic [RW-1:0] a_d, b_d, a_q, b_q;

            if (k == 0) begin : g_nx
                assign a_d = a[WIDTH-1:HI];
                assign b_d = b[WIDTH-1:HI];
            end else begin : g_nx
                assign a_d = stg[k-1].g_rem.a_q[RW+CHUNK-1:CHUNK];
                assign b_d = stg[k-1].g_rem.b_q[RW+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].vld_q;
    assign sum       = stg[STAGES-1].sum_q;
    assign carry_out = stg[STAGES-1].cry_q;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

`ifdef PIPE_ADD_OVF_EN
    // The final slice still sees the operand MSBs, so overflow is decided there.
    logic ovf_d;
    assign ovf_d = (stg[STAGES-1].a_c[CHUNK-1] == stg[STAGES-1].b_c[CHUNK-1]) &&
                   (stg[STAGES-1].s_c[CHUNK-1] != stg[STAGES-1].a_c[CHUNK-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (!stall) begin
            overflow <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4) with an in-order result scoreboard.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef PIPE_ADD_OVF_EN
    logic             overflow;
`endif

    int errs   = 0;
    int checks = 0;
    int outs   = 0;
    int send_waits = 0;
    bit mon_en = 1'b0;
    logic [WIDTH:0] sb[$];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef PIPE_ADD_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected results are queued at acceptance and compared at transfer.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (out_valid && out_ready) begin
                outs++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    check("sb_result", {31'd0, carry_out, sum}, {31'd0, sb.pop_front()});
                end
            end
            if (in_valid && in_ready)
                sb.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        int n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        carry_in = c;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        send_waits += n;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        if (!ok) check("wait_out_timeout", 64'd0, 64'd1);
    endtask

    logic [WIDTH-1:0] held_sum;
    logic             held_c;
    int               seen;
    int               outs0;
    bit               ok;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        carry_in = 1'b0;
        out_ready = 1'b1;

        // Reset with in_valid held high
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_in_ready", in_ready, 1);

        // Release: the held operand is accepted at the next edge; result exactly STAGES cycles later
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            check("latency_early", out_valid, 0);
            tick();
        end
        check("latency_valid", out_valid, 1);
        check("wrap_sum", sum, 32'h0000_0000);
        check("wrap_carry_out", carry_out, 1);
        repeat (3) tick();

        send(32'h1234_5678, 32'h0000_FFFF, 1'b1);
        wait_out(ok);
        if (ok) begin
            check("dir2_sum", sum, 32'h1235_5678);
            check("dir2_carry_out", carry_out, 0);
        end
        tick();

        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_out(ok);
        if (ok) check("chunk_carry_sum", sum, 32'h0000_0100);
        tick();

`ifdef PIPE_ADD_OVF_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_out(ok);
        if (ok) begin
            check("ovf_pos_flag", overflow, 1);
            check("ovf_pos_sum", sum, 32'h8000_0000);
        end
        tick();
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_out(ok);
        if (ok) begin
            check("ovf_neg_flag", overflow, 1);
            check("ovf_neg_carry_out", carry_out, 1);
            check("ovf_neg_sum", sum, 32'h0000_0000);
        end
        tick();
        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        wait_out(ok);
        if (ok) check("ovf_none_flag", overflow, 0);
        tick();
`endif

        // Streaming: back-to-back accepts, one result per cycle
        repeat (5) tick();
        outs0 = outs;
        send_waits = 0;
        for (int i = 0; i < 1000; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
        repeat (STAGES + 2) tick();
        check("stream_no_waits", send_waits, 0);
        check("stream_result_count", outs - outs0, 1000);
        check("stream_sb_empty", sb.size(), 0);

        // Backpressure with a full pipe
        out_ready = 1'b0;
        outs0 = outs;
        send(32'h1000_0000, 32'h0F00_0000, 1'b1);
        send(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0);
        send(32'h8000_0001, 32'h8000_0001, 1'b1);
        check("bp_out_valid", out_valid, 1);
        check("bp_first_sum", sum, 32'h1F00_0001);
        held_sum = sum;
        held_c = carry_out;
        in_valid = 1'b1;
        a = 32'h0000_0005;
        b = 32'h0000_0007;
        carry_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_held", sum, held_sum);
            check("bp_carry_held", carry_out, held_c);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (STAGES + 3) tick();
        check("bp_result_count", outs - outs0, 5);
        check("bp_sb_empty", sb.size(), 0);

        // Mid-flight reset with 3 operations in the pipe
        out_ready = 1'b0;
        send(32'h0000_0011, 32'h0000_0022, 1'b0);
        send(32'h0000_0033, 32'h0000_0044, 1'b0);
        send(32'h0000_0055, 32'h0000_0066, 1'b0);
        tick();
        check("mid_out_valid_before", out_valid, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid_fall", out_valid, 0);
        check("mid_sum_cleared", sum, 0);
        check("mid_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_no_stale_results", seen, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
